// File: rtl/param_updown_counter.sv
// ---------------------------------------------------------------------------
// param_updown_counter
//
// Parametrised up/down counter. It can wrap or saturate at its bounds, and it
// can count on an enable level or on the rising edge of the enable. It is the
// common counting primitive for event tallies (pulse inputs) and for timers
// (every-cycle enable).
//
// Parameters:
//   WIDTH       - count width, 2..16
//   MAX         - highest count value; the modulus is MAX+1
//   RESET_VALUE - value loaded on reset (<= MAX)
//   SATURATE    - 0: wrap at the bounds, 1: hold at the bounds
//   EDGE_MODE   - 0: count every cycle en is high, 1: count once per en rise
//
// Ports:
//   clk        in   clock; all state changes on posedge
//   reset      in   synchronous active-high reset
//   en         in   count request (level or edge, depending on EDGE_MODE)
//   up         in   direction: 1 = increment, 0 = decrement
//   load       in   synchronous parallel load (has priority over counting)
//   load_value in   value to load; values above MAX are clamped to MAX
//   count      out  registered count
//   zero       out  high while count == 0 (decoded from the count register)
//   tc         out  registered one-cycle terminal-count pulse
// ---------------------------------------------------------------------------
module param_updown_counter #(
    parameter int WIDTH       = 4,
    parameter int MAX         = 2**WIDTH - 1,
    parameter int RESET_VALUE = MAX,
    parameter int SATURATE    = 0,
    parameter int EDGE_MODE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc
);

    // Bounds are carried one bit wider than the count so every comparison and
    // sum happens without truncation.
    localparam logic [WIDTH:0]   MAX_W   = (WIDTH+1)'(MAX);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH:0]   ONE_W   = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_en_q;

    logic             w_ev;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic             w_at_max;
    logic             w_at_zero;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_tc;

    // Loads above MAX clamp to MAX; anything else passes through unchanged.
    function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] res;
        if ({1'b0, v} > MAX_W) begin
            res = MAX_W[WIDTH-1:0];
        end else begin
            res = v;
        end
        return res;
    endfunction

    // In edge mode only a low-to-high transition of en counts. en_q is set to
    // 1 by reset, so an en held high across reset does not fire an event.
    assign w_ev = (EDGE_MODE != 0) ? (en & ~r_en_q) : en;

    // WIDTH+1-bit neighbours of the current count. The top bits tell us when
    // we stepped past MAX (increment) or borrowed below zero (decrement).
    assign w_inc     = {1'b0, r_count} + ONE_W;
    assign w_dec     = {1'b0, r_count} - ONE_W;
    assign w_at_max  = (w_inc > MAX_W);
    assign w_at_zero = w_dec[WIDTH];

    // Next-state decode: load beats counting, and counting beats hold.
    always_comb begin
        w_next_count = r_count;
        w_next_tc    = 1'b0;
        if (load) begin
            w_next_count = clamp_to_max(load_value);
            w_next_tc    = 1'b0;
        end else if (w_ev) begin
            if (up) begin
                if (w_at_max) begin
                    w_next_tc = 1'b1;
                    if (SATURATE != 0) begin
                        w_next_count = r_count;
                    end else begin
                        w_next_count = {WIDTH{1'b0}};
                    end
                end else begin
                    w_next_count = w_inc[WIDTH-1:0];
                end
            end else begin
                if (w_at_zero) begin
                    w_next_tc = 1'b1;
                    if (SATURATE != 0) begin
                        w_next_count = r_count;
                    end else begin
                        w_next_count = MAX_W[WIDTH-1:0];
                    end
                end else begin
                    w_next_count = w_dec[WIDTH-1:0];
                end
            end
        end else begin
            w_next_count = r_count;
            w_next_tc    = 1'b0;
        end
    end

    // Count, terminal-count and en-history registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= RESET_W;
            r_tc    <= 1'b0;
            r_en_q  <= 1'b1;
        end else begin
            r_count <= w_next_count;
            r_tc    <= w_next_tc;
            r_en_q  <= en;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign zero  = (r_count == {WIDTH{1'b0}});

endmodule

// File: tb/tb_param_updown_counter.sv
// ---------------------------------------------------------------------------
// Testbench for param_updown_counter. Five differently parameterised
// instances share one stimulus stream. Each instance is compared every cycle
// against a behavioural model built from the counting rules. Directed
// sequences check the expected values from the counting rules with literal
// constants. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_param_updown_counter;

    localparam int N = 5;

    // Instance parameter tables (index = instance number).
    int p_max  [N] = '{15, 9, 9, 15, 20};
    int p_rv   [N] = '{15, 9, 9, 15, 0};
    int p_sat  [N] = '{0,  0, 1, 0,  1};
    int p_edge [N] = '{0,  0, 0, 1,  1};

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_value;
    logic       lv_hi;
    logic [4:0] lv5;

    logic [3:0] c0, c1, c2, c3;
    logic [4:0] c4;
    logic [N-1:0] z_s, t_s;

    int m_count [N];
    int m_tc    [N];
    int m_enq   [N];

    int n_checks;
    int n_fails;

    assign lv5 = {lv_hi, load_value};

    param_updown_counter u0 (.clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_value(load_value), .count(c0), .zero(z_s[0]), .tc(t_s[0]));
    param_updown_counter #(.WIDTH(4), .MAX(9)) u1 (.clk(clk), .reset(reset), .en(en), .up(up),
        .load(load), .load_value(load_value), .count(c1), .zero(z_s[1]), .tc(t_s[1]));
    param_updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(1)) u2 (.clk(clk), .reset(reset),
        .en(en), .up(up), .load(load), .load_value(load_value), .count(c2), .zero(z_s[2]),
        .tc(t_s[2]));
    param_updown_counter #(.EDGE_MODE(1)) u3 (.clk(clk), .reset(reset), .en(en), .up(up),
        .load(load), .load_value(load_value), .count(c3), .zero(z_s[3]), .tc(t_s[3]));
    param_updown_counter #(.WIDTH(5), .MAX(20), .RESET_VALUE(0), .SATURATE(1), .EDGE_MODE(1)) u4 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_value(lv5),
        .count(c4), .zero(z_s[4]), .tc(t_s[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int obs_count(input int k);
        case (k)
            0:       return int'(c0);
            1:       return int'(c1);
            2:       return int'(c2);
            3:       return int'(c3);
            default: return int'(c4);
        endcase
    endfunction

    // Behavioural model: applies one clock edge of the counting rules.
    task automatic model_edge();
        int ev;
        int lv;
        for (int k = 0; k < N; k++) begin
            lv = (k == 4) ? int'(lv5) : int'(load_value);
            if (reset) begin
                m_count[k] = p_rv[k];
                m_tc[k]    = 0;
                m_enq[k]   = 1;
            end else begin
                ev = (p_edge[k] != 0) ? int'(en && (m_enq[k] == 0)) : int'(en);
                m_enq[k] = int'(en);
                if (load) begin
                    m_count[k] = (lv > p_max[k]) ? p_max[k] : lv;
                    m_tc[k]    = 0;
                end else if (ev != 0) begin
                    if (up) begin
                        if (m_count[k] == p_max[k]) begin
                            m_tc[k]    = 1;
                            m_count[k] = (p_sat[k] != 0) ? m_count[k] : 0;
                        end else begin
                            m_tc[k]    = 0;
                            m_count[k] = m_count[k] + 1;
                        end
                    end else begin
                        if (m_count[k] == 0) begin
                            m_tc[k]    = 1;
                            m_count[k] = (p_sat[k] != 0) ? 0 : p_max[k];
                        end else begin
                            m_tc[k]    = 0;
                            m_count[k] = m_count[k] - 1;
                        end
                    end
                end else begin
                    m_tc[k] = 0;
                end
            end
        end
    endtask

    // Advance one clock, update the model and compare every instance.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < N; k++) begin
            check_val($sformatf("u%0d.count", k), obs_count(k), m_count[k]);
            check_val($sformatf("u%0d.zero", k), int'(z_s[k]), int'(m_count[k] == 0));
            check_val($sformatf("u%0d.tc", k), int'(t_s[k]), m_tc[k]);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic u,
                         input logic l, input logic [3:0] lv);
        reset = r; en = e; up = u; load = l; load_value = lv; lv_hi = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        for (int k = 0; k < N; k++) begin
            m_count[k] = 0; m_tc[k] = 0; m_enq[k] = 1;
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

        // Reset held 3 cycles with en=1, up=0.
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("rst.count", int'(c0), 15);
            check_val("rst.tc", int'(t_s[0]), 0);
        end
        check_val("rst.zero_rv_max", int'(z_s[0]), 0);
        check_val("rst.zero_rv_0", int'(z_s[4]), 1);

        // Release with en held: count 14..0 then wrap to 15 with a tc pulse.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            step();
            check_val("down.count", int'(c0), (i < 15) ? (14 - i) : 15);
            check_val("down.tc", int'(t_s[0]), int'(i == 15));
            if (i == 4) check_val("edge.held_en", int'(c3), 15);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("hold.count", int'(c0), 15);
        end

        // MAX=9 wrap: from 7 count up 8,9,0,1 (tc on 0) then down 0,9 (tc on 9).
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd7);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("mod9.up", int'(c1), (i == 0) ? 8 : (i == 1) ? 9 : (i == 2) ? 0 : 1);
            check_val("mod9.up_tc", int'(t_s[1]), int'(i == 2));
        end
        up = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check_val("mod9.dn", int'(c1), (i == 0) ? 0 : 9);
            check_val("mod9.dn_tc", int'(t_s[1]), int'(i == 1));
        end

        // Saturating MAX=9: from 8 up with en held gives 9,9,9; then down to 8.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd8);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("sat.count", int'(c2), 9);
            check_val("sat.tc", int'(t_s[2]), int'(i > 0));
        end
        up = 1'b0;
        step();
        check_val("sat.back", int'(c2), 8);
        check_val("sat.back_tc", int'(t_s[2]), 0);

        // Edge mode: three 1-cycle pulses and one 4-cycle pulse from 15.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int p = 0; p < 4; p++) begin
            en = 1'b1;
            for (int i = 0; i < ((p == 3) ? 4 : 1); i++) step();
            en = 1'b0;
            step();
        end
        check_val("edge.pulses", int'(c3), 11);

        // Load: clamp with coincident ev, plain load, reset beats load.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd12);
        step();
        check_val("load.clamp", int'(c1), 9);
        load_value = 4'd3;
        step();
        check_val("load.plain", int'(c1), 3);
        reset = 1'b1;
        step();
        check_val("load.reset_wins", int'(c1), 9);

        // zero: decrement from 2 through 0 then wrap to 9.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("zero.count", int'(c1), (i == 0) ? 1 : (i == 1) ? 0 : 9);
            check_val("zero.flag", int'(z_s[1]), int'(i == 1));
        end

        // Randomized phase, checked against the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(63) == 0);
            load       = ($urandom_range(15) == 0);
            en         = ($urandom_range(2) != 0);
            up         = $urandom_range(1) != 0;
            load_value = 4'($urandom_range(15));
            lv_hi      = $urandom_range(1) != 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
